// File: rtl/connect_n_game_if.sv
// Button/display bundle of the Connect-N core: three single-cycle
// button pulses towards the game, board and status back from it.
interface connect_n_game_if #(
    parameter int COLS  = 7,
    parameter int ROWS  = 6,
    parameter int CUR_W = 3
);
    logic                     right;
    logic                     left;
    logic                     enter;
    logic [2*ROWS*COLS-1:0]   board;
    logic [CUR_W-1:0]         cursor;
    logic                     player_colour;
    logic                     change;
    logic                     reject;
    logic                     busy;
    logic [1:0]               win;

    modport master (
        output right, left, enter,
        input  board, cursor, player_colour, change, reject, busy, win
    );

    modport slave (
        input  right, left, enter,
        output board, cursor, player_colour, change, reject, busy, win
    );
endinterface

// File: rtl/connect_n_game.sv
// Parametrised Connect-N game core: cursor, disc drop, and a fixed
// four-cycle line check through the last placed disc, then resolve.
module connect_n_game #(
    parameter int COLS    = 7,
    parameter int ROWS    = 6,
    parameter int WIN_LEN = 4,
    parameter int CUR_W   = 3
) (
    input  logic            clk,
    input  logic            reset,
    connect_n_game_if.slave bus
);
    localparam int CELLS = ROWS * COLS;
    localparam int H_W   = $clog2(ROWS + 1);
    localparam int MC_W  = $clog2(CELLS + 1);
    localparam int BW    = 2 * CELLS;

    localparam logic [2:0] PLAY    = 3'd0;
    localparam logic [2:0] CHECK0  = 3'd1;
    localparam logic [2:0] CHECK1  = 3'd2;
    localparam logic [2:0] CHECK2  = 3'd3;
    localparam logic [2:0] CHECK3  = 3'd4;
    localparam logic [2:0] RESOLVE = 3'd5;
    localparam logic [2:0] OVER    = 3'd6;

    logic [2:0]       state;
    logic [BW-1:0]    board;
    logic [H_W-1:0]   heights [COLS];
    logic [MC_W-1:0]  move_count;
    logic [CUR_W-1:0] cursor;
    logic [H_W-1:0]   placed_row;
    logic [CUR_W-1:0] placed_col;
    logic             player_colour;
    logic             change;
    logic             reject;
    logic             busy;
    logic             found;
    logic [1:0]       win;
    logic [1:0]       mover;
    logic             line_hit;

    // Player 0 owns code 01, player 1 owns code 10.
    assign mover = {player_colour, ~player_colour};

    function automatic logic [1:0] cell_at(input logic [BW-1:0] b, input int c, input int r);
        logic [1:0] v;
        v = 2'b00;
        if (c >= 0 && c < COLS && r >= 0 && r < ROWS)
            v = b[2*(c*ROWS+r) +: 2];
        return v;
    endfunction

    // Run length through the placed cell along the direction of the current
    // CHECK state; each side stops at the first foreign/empty/off-board cell.
    always_comb begin : line_scan
        int   dc;
        int   dr;
        int   run;
        int   c;
        int   r;
        logic fwd;
        logic bwd;
        dc       = 0;
        dr       = 0;
        run      = 1;
        c        = 0;
        r        = 0;
        fwd      = 1'b1;
        bwd      = 1'b1;
        line_hit = 1'b0;
        case (state)
            CHECK0:  begin dc = 1; dr = 0;  end
            CHECK1:  begin dc = 0; dr = 1;  end
            CHECK2:  begin dc = 1; dr = 1;  end
            CHECK3:  begin dc = 1; dr = -1; end
            default: begin dc = 0; dr = 0;  end
        endcase
        for (int k = 1; k < WIN_LEN; k++) begin
            c = int'(placed_col) + k * dc;
            r = int'(placed_row) + k * dr;
            if (fwd && cell_at(board, c, r) == mover) run = run + 1;
            else fwd = 1'b0;
            c = int'(placed_col) - k * dc;
            r = int'(placed_row) - k * dr;
            if (bwd && cell_at(board, c, r) == mover) run = run + 1;
            else bwd = 1'b0;
        end
        line_hit = (dc != 0 || dr != 0) && (run >= WIN_LEN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= PLAY;
            board         <= '0;
            for (int i = 0; i < COLS; i++) heights[i] <= '0;
            move_count    <= '0;
            cursor        <= '0;
            placed_row    <= '0;
            placed_col    <= '0;
            player_colour <= 1'b0;
            change        <= 1'b0;
            reject        <= 1'b0;
            busy          <= 1'b0;
            found         <= 1'b0;
            win           <= 2'b00;
        end else begin
            change <= 1'b0;
            reject <= 1'b0;
            case (state)
                PLAY: begin
                    if (bus.enter) begin
                        if (heights[cursor] == H_W'(ROWS)) begin
                            reject <= 1'b1;
                        end else begin
                            board[2*(int'(cursor)*ROWS + int'(heights[cursor])) +: 2] <= mover;
                            heights[cursor] <= heights[cursor] + H_W'(1);
                            move_count      <= move_count + MC_W'(1);
                            placed_row      <= heights[cursor];
                            placed_col      <= cursor;
                            found           <= 1'b0;
                            busy            <= 1'b1;
                            state           <= CHECK0;
                        end
                    end else if (bus.right && !bus.left) begin
                        cursor <= (cursor == CUR_W'(COLS - 1)) ? '0 : cursor + CUR_W'(1);
                    end else if (bus.left && !bus.right) begin
                        cursor <= (cursor == '0) ? CUR_W'(COLS - 1) : cursor - CUR_W'(1);
                    end
                end
                CHECK0, CHECK1, CHECK2, CHECK3: begin
                    if (line_hit) found <= 1'b1;
                    state <= state + 3'd1;
                end
                RESOLVE: begin
                    busy <= 1'b0;
                    // A line completed on the last free cell counts as a win.
                    if (found) begin
                        win   <= mover;
                        state <= OVER;
                    end else if (move_count == MC_W'(CELLS)) begin
                        win   <= 2'b11;
                        state <= OVER;
                    end else begin
                        player_colour <= ~player_colour;
                        change        <= 1'b1;
                        state         <= PLAY;
                    end
                end
                OVER:    state <= OVER;
                default: state <= PLAY;
            endcase
        end
    end

    assign bus.board         = board;
    assign bus.cursor        = cursor;
    assign bus.player_colour = player_colour;
    assign bus.change        = change;
    assign bus.reject        = reject;
    assign bus.busy          = busy;
    assign bus.win           = win;
endmodule

// File: tb/tb_connect_n_game.sv
// Bench for connect_n_game: directed scenarios plus random games on the
// default 7x6 board checked against a whole-board reference model.
module tb_connect_n_game;
    localparam int COLS    = 7;
    localparam int ROWS    = 6;
    localparam int WIN_LEN = 4;
    localparam int CUR_W   = 3;
    localparam int CELLS   = COLS * ROWS;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    connect_n_game_if #(.COLS(COLS), .ROWS(ROWS), .CUR_W(CUR_W)) bus();
    connect_n_game_if #(.COLS(3), .ROWS(2), .CUR_W(2)) sbus();

    connect_n_game #(.COLS(COLS), .ROWS(ROWS), .WIN_LEN(WIN_LEN), .CUR_W(CUR_W)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );
    connect_n_game #(.COLS(3), .ROWS(2), .WIN_LEN(3), .CUR_W(2)) sdut (
        .clk(clk), .reset(reset), .bus(sbus.slave)
    );

    int tests = 0;
    int failures = 0;

    int         mcell [COLS][ROWS];
    int         mheight [COLS];
    int         mcur;
    int         mplayer;
    int         mmoves;
    logic [1:0] mwin;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        tests++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic l, input logic e);
        bus.right = r;
        bus.left  = l;
        bus.enter = e;
        @(posedge clk);
        #1;
        bus.right = 1'b0;
        bus.left  = 1'b0;
        bus.enter = 1'b0;
    endtask

    task automatic smallStimulus(input logic r, input logic e);
        sbus.right = r;
        sbus.left  = 1'b0;
        sbus.enter = e;
        @(posedge clk);
        #1;
        sbus.right = 1'b0;
        sbus.enter = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic modelReset();
        for (int c = 0; c < COLS; c++) begin
            mheight[c] = 0;
            for (int r = 0; r < ROWS; r++) mcell[c][r] = 0;
        end
        mcur = 0;
        mplayer = 0;
        mmoves = 0;
        mwin = 2'b00;
    endtask

    task automatic doReset();
        bus.right = 1'b0;
        bus.left  = 1'b0;
        bus.enter = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        modelReset();
    endtask

    function automatic logic [127:0] modelBoard();
        logic [127:0] v;
        v = '0;
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                v[2*(c*ROWS+r) +: 2] = 2'(mcell[c][r]);
        return v;
    endfunction

    // Scan every cell and every direction for a full-length run.
    function automatic logic [1:0] modelWinner();
        int dcs [4];
        int drs [4];
        dcs = '{1, 0, 1, 1};
        drs = '{0, 1, 1, -1};
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                for (int d = 0; d < 4; d++) begin
                    int  cc;
                    int  rr;
                    bit  ok;
                    ok = (mcell[c][r] != 0);
                    for (int k = 1; k < WIN_LEN; k++) begin
                        cc = c + k * dcs[d];
                        rr = r + k * drs[d];
                        if (cc < 0 || cc >= COLS || rr < 0 || rr >= ROWS) ok = 0;
                        else if (mcell[cc][rr] != mcell[c][r]) ok = 0;
                    end
                    if (ok) return 2'(mcell[c][r]);
                end
        return 2'b00;
    endfunction

    task automatic modelStep(input logic r, input logic l, input logic e, input string tag);
        bit         accept;
        bit         refuse;
        bit         chg;
        logic [1:0] w;
        accept = 0;
        refuse = 0;
        chg = 0;
        if (mwin == 2'b00) begin
            if (e) begin
                if (mheight[mcur] == ROWS) refuse = 1;
                else accept = 1;
            end else if (r && !l) mcur = (mcur + 1) % COLS;
            else if (l && !r) mcur = (mcur + COLS - 1) % COLS;
        end
        if (accept) begin
            mcell[mcur][mheight[mcur]] = mplayer + 1;
            mheight[mcur]++;
            mmoves++;
        end
        applyStimulus(r, l, e);
        checkOutput({tag, " cursor"}, 128'(bus.cursor), 128'(mcur));
        checkOutput({tag, " board"}, 128'(bus.board), modelBoard());
        checkOutput({tag, " reject"}, 128'(bus.reject), 128'(refuse));
        if (accept) begin
            checkOutput({tag, " busy_set"}, 128'(bus.busy), 128'(1));
            idle(5);
            w = modelWinner();
            if (w != 2'b00) mwin = w;
            else if (mmoves == CELLS) mwin = 2'b11;
            else begin
                mplayer = 1 - mplayer;
                chg = 1;
            end
            checkOutput({tag, " win"}, 128'(bus.win), 128'(mwin));
            checkOutput({tag, " player"}, 128'(bus.player_colour), 128'(mplayer));
            checkOutput({tag, " busy_clr"}, 128'(bus.busy), 128'(0));
            checkOutput({tag, " change"}, 128'(bus.change), 128'(chg));
        end else begin
            checkOutput({tag, " busy"}, 128'(bus.busy), 128'(0));
            checkOutput({tag, " win_hold"}, 128'(bus.win), 128'(mwin));
        end
    endtask

    task automatic dropIn(input int col, input string tag);
        int guard;
        guard = 0;
        while (mcur != col && guard < COLS) begin
            modelStep(1'b1, 1'b0, 1'b0, tag);
            guard++;
        end
        modelStep(1'b0, 1'b0, 1'b1, tag);
    endtask

    initial begin
        int diag_cols [10];
        diag_cols = '{0, 0, 0, 3, 1, 0, 1, 1, 2, 2};
        sbus.right = 1'b0;
        sbus.left  = 1'b0;
        sbus.enter = 1'b0;

        doReset();
        checkOutput("rst board", 128'(bus.board), 128'(0));
        checkOutput("rst cursor", 128'(bus.cursor), 128'(0));
        checkOutput("rst player", 128'(bus.player_colour), 128'(0));
        checkOutput("rst change", 128'(bus.change), 128'(0));
        checkOutput("rst reject", 128'(bus.reject), 128'(0));
        checkOutput("rst busy", 128'(bus.busy), 128'(0));
        checkOutput("rst win", 128'(bus.win), 128'(0));
        checkOutput("rst small board", 128'(sbus.board), 128'(0));

        modelStep(1'b0, 1'b1, 1'b0, "wrap left");
        checkOutput("wrap left abs", 128'(bus.cursor), 128'(6));
        modelStep(1'b1, 1'b0, 1'b0, "wrap right");
        checkOutput("wrap right abs", 128'(bus.cursor), 128'(0));
        modelStep(1'b1, 1'b1, 1'b0, "both dirs");
        checkOutput("both dirs abs", 128'(bus.cursor), 128'(0));

        doReset();
        for (int i = 0; i < 7; i++) dropIn(i % 2, "vert");
        checkOutput("vert win abs", 128'(bus.win), 128'(1));
        checkOutput("vert busy abs", 128'(bus.busy), 128'(0));
        checkOutput("vert change abs", 128'(bus.change), 128'(0));
        modelStep(1'b0, 1'b0, 1'b1, "over enter");
        modelStep(1'b1, 1'b0, 1'b0, "over right");

        doReset();
        for (int i = 0; i < 6; i++) dropIn(3, "fill");
        modelStep(1'b0, 1'b0, 1'b1, "full col");
        checkOutput("full reject abs", 128'(bus.reject), 128'(1));
        idle(1);
        checkOutput("full reject drop", 128'(bus.reject), 128'(0));
        checkOutput("full player", 128'(bus.player_colour), 128'(0));
        checkOutput("full moves", 128'(dut.move_count), 128'(6));
        checkOutput("full busy", 128'(bus.busy), 128'(0));

        doReset();
        for (int i = 0; i < 10; i++) dropIn(diag_cols[i], "diag");
        checkOutput("diag win abs", 128'(bus.win), 128'(2));

        doReset();
        dropIn(2, "pre mid");
        applyStimulus(1'b0, 1'b0, 1'b1);
        idle(2);
        checkOutput("mid busy", 128'(bus.busy), 128'(1));
        bus.enter = 1'b1;
        bus.right = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.enter = 1'b0;
        bus.right = 1'b0;
        modelReset();
        checkOutput("mid board", 128'(bus.board), 128'(0));
        checkOutput("mid busy clr", 128'(bus.busy), 128'(0));
        checkOutput("mid win", 128'(bus.win), 128'(0));
        checkOutput("mid player", 128'(bus.player_colour), 128'(0));
        checkOutput("mid cursor", 128'(bus.cursor), 128'(0));
        dropIn(0, "after mid");

        doReset();
        for (int i = 0; i < 6; i++) begin
            smallStimulus(1'b0, 1'b1);
            idle(5);
            if (i == 4) checkOutput("draw pre win", 128'(sbus.win), 128'(0));
            if (i < 5) smallStimulus(1'b1, 1'b0);
        end
        checkOutput("draw board", 128'(sbus.board), 128'(12'h969));
        checkOutput("draw win", 128'(sbus.win), 128'(3));
        checkOutput("draw player", 128'(sbus.player_colour), 128'(1));
        checkOutput("draw busy", 128'(sbus.busy), 128'(0));

        for (int g = 0; g < 4; g++) begin
            doReset();
            for (int s = 0; s < 150 && mwin == 2'b00; s++) begin
                case ($urandom_range(0, 5))
                    0, 1:    modelStep(1'b1, 1'b0, 1'b0, "rnd right");
                    2:       modelStep(1'b0, 1'b1, 1'b0, "rnd left");
                    3, 4:    modelStep(1'b0, 1'b0, 1'b1, "rnd enter");
                    default: modelStep(1'b1, 1'b1, 1'b0, "rnd both");
                endcase
            end
            modelStep(1'b0, 1'b0, 1'b1, "rnd tail");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
